e3_mul_seq: RTL and testbench

E3_MUL_SEQ -- requirements
Module: e3_mul_seq

---
 rtl/e3_pkg.sv | 24 ++
 rtl/e3_mult.sv | 13 +
 rtl/e3_mul_seq.sv | 138 +++++++++++++
 tb/tb_e3_mul_seq.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/e3_pkg.sv
// Shared Excess-3 constants, FSM state type and digit-validity helper.
package e3_pkg;

  localparam int unsigned DIG_W = 4;

  // Excess-3 offset; also the code of decimal zero.
  localparam logic [DIG_W-1:0] E3_OFFSET = 4'd3;
  // Legal Excess-3 code range (decimal 0..9).
  localparam logic [DIG_W-1:0] E3_MIN = 4'b0011;
  localparam logic [DIG_W-1:0] E3_MAX = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    FIN  = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when the 4-bit code is a legal Excess-3 digit.
  function automatic logic e3_valid(input logic [DIG_W-1:0] d);
    return (d >= E3_MIN) && (d <= E3_MAX);
  endfunction

endpackage

// File: rtl/e3_mult.sv
// Combinational single-digit multiplier on decoded (0..9) digits.
module e3_mult (
  input  logic [3:0] dig_a,
  input  logic [3:0] dig_b,
  output logic [6:0] prod_c
);

  // Product of two decimal digits, at most 81.
  always_comb begin
    prod_c = 7'(dig_a) * 7'(dig_b);
  end

endmodule

// File: rtl/e3_mul_seq.sv
// Sequential Excess-3 multiplier: NDIG-digit operand times one digit, LSD first.
module e3_mul_seq
  import e3_pkg::*;
#(
  parameter int unsigned NDIG = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [4*NDIG-1:0]     a,
  input  logic [3:0]            b,
  output logic                  busy,
  output logic                  done,
  output logic [4*(NDIG+1)-1:0] result,
  output logic                  err
);

  localparam int unsigned IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int unsigned RES_W = 4 * (NDIG + 1);

  state_e             state_q, state_d;
  logic [4*NDIG-1:0]  a_q, a_d;
  logic [3:0]         b_q, b_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [3:0]         carry_q, carry_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic               in_ok;
  logic [3:0]         dig_dec;
  logic [3:0]         b_dec;
  logic [6:0]         prod;
  logic [6:0]         p_sum;

  // All incoming digits must be legal Excess-3 codes.
  always_comb begin
    in_ok = e3_valid(b);
    for (int i = 0; i < int'(NDIG); i++) begin
      if (!e3_valid(a[4*i +: 4])) in_ok = 1'b0;
    end
  end

  // Decode the current digit and latched multiplier for the shared digit multiplier.
  always_comb begin
    dig_dec = a_q[4*int'(idx_q) +: 4] - E3_OFFSET;
    b_dec   = b_q - E3_OFFSET;
  end

  e3_mult u_mult (
    .dig_a  (dig_dec),
    .dig_b  (b_dec),
    .prod_c (prod)
  );

  // Partial product plus incoming carry, never above 89.
  always_comb begin
    p_sum = prod + 7'(carry_q);
  end

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          busy_d  = 1'b1;
          carry_d = 4'd0;
          idx_d   = '0;
          state_d = in_ok ? MUL : DONE;
        end
      end
      MUL: begin
        result_d[4*int'(idx_q) +: 4] = 4'(p_sum % 7'd10) + E3_OFFSET;
        carry_d = 4'(p_sum / 7'd10);
        idx_d   = IW'(idx_q + 1'b1);
        if (idx_q == IW'(NDIG - 1)) state_d = FIN;
      end
      FIN: begin
        result_d[4*NDIG +: 4] = carry_q + E3_OFFSET;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        state_d = IDLE;
      end
      DONE: begin
        result_d = {(NDIG+1){E3_OFFSET}};
        done_d   = 1'b1;
        busy_d   = 1'b0;
        err_d    = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= {NDIG{E3_OFFSET}};
      b_q      <= E3_OFFSET;
      idx_q    <= '0;
      carry_q  <= 4'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      result_q <= {(NDIG+1){E3_OFFSET}};
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign err    = err_q;
  assign result = result_q;

endmodule

// File: tb/tb_e3_mul_seq.sv
// Directed bench for e3_mul_seq with NDIG=4.
module tb_e3_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [3:0]  b;
  logic        busy;
  logic        done;
  logic [19:0] result;
  logic        err;

  int total = 0;
  int bad   = 0;

  e3_mul_seq #(.NDIG(4)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .result (result),
    .err    (err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit past the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Pulse start for one edge, then wait (bounded) for done and check everything.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [3:0] bv,
                        input logic [19:0] er, input logic ee, input int lat);
    int n;
    a = av; b = bv; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy_k"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      tick();
      n++;
      if (!done) chk({tag, "_busy"}, 32'(busy), 32'd1);
    end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_res"}, 32'(result), 32'(er));
    chk({tag, "_err"}, 32'(err), 32'(ee));
    chk({tag, "_busy_end"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(result), 32'(er));
    chk({tag, "_err_hold"}, 32'(err), 32'(ee));
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; a = 16'h3333; b = 4'h3;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_res", 32'(result), 32'h33333);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Main arithmetic vectors
    run_op("max",  16'hCCCC, 4'hC, 20'hBCCC4, 1'b0, 5);
    run_op("mid",  16'h4567, 4'h8, 20'h394A3, 1'b0, 5);
    run_op("zero", 16'h3333, 4'hA, 20'h33333, 1'b0, 5);
    run_op("one",  16'h4444, 4'h4, 20'h34444, 1'b0, 5);

    // Illegal digit, then recovery
    run_op("bad_a", 16'h45F7, 4'h8, 20'h33333, 1'b1, 1);
    run_op("bad_b", 16'h4444, 4'h2, 20'h33333, 1'b1, 1);
    run_op("recov", 16'h4567, 4'h8, 20'h394A3, 1'b0, 5);

    // start re-pulsed while busy is ignored
    a = 16'hCCCC; b = 4'hC; start = 1'b1;
    tick();                 // edge k
    start = 1'b0;
    tick();                 // k+1
    a = 16'h4567; b = 4'h8; start = 1'b1;
    tick();                 // k+2, ignored
    start = 1'b0;
    n = 2;
    while (!done && n < 20) begin tick(); n++; end
    chk("ign_lat", 32'(n), 32'd5);
    chk("ign_res", 32'(result), 32'hBCCC4);
    chk("ign_err", 32'(err), 32'd0);
    tick();

    // start held high: back-to-back, second done 6 edges after the first
    a = 16'h4444; b = 4'h4; start = 1'b1;
    n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("b2b_first", 32'(done), 32'd1);
    n = 0;
    tick(); n++;
    while (!done && n < 20) begin tick(); n++; end
    start = 1'b0;
    chk("b2b_gap", 32'(n), 32'd6);
    chk("b2b_res", 32'(result), 32'h34444);
    tick();
    chk("b2b_idle", 32'(busy), 32'd0);

    // Reset mid-operation
    a = 16'hCCCC; b = 4'hC; start = 1'b1;
    tick();                 // edge k
    start = 1'b0;
    tick(); tick();         // k+2
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_res", 32'(result), 32'h33333);
    chk("mrst_err", 32'(err), 32'd0);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) n++;
    end
    chk("mrst_nodone", 32'(n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mrst_after", 32'(done), 32'd0);
    run_op("post", 16'h4567, 4'h8, 20'h394A3, 1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
